// File: rtl/if_fetch_buffer_if.sv
// Instruction-memory fetch port shared by the prefetch buffer and memory.
// The fetch buffer drives the request side; memory answers with ack/data.
interface if_fetch_buffer_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: producer end of the IF->ID stage.
// Generates sequential fetch addresses, runs a one-outstanding req/ack
// handshake with instruction memory and buffers returned words in a small
// prefetch FIFO whose head is presented to the IF/ID register.
// Optional feature: define IF_DELAY_SLOT_EN to keep the FIFO head (the
// branch delay slot) on a redirect when the head is not consumed that cycle.
module if_fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          stall,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_i,
    if_fetch_buffer_if.master   imem,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_inst,
    output logic                stallreq_if
);

    localparam int         PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   drain_addr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_after;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic valid;
    logic pop;
    logic req_ack;
    logic push;
    logic unused_bits;

    // Only stall[1] gates the IF->ID hand-over; targets are word aligned.
    assign unused_bits = ^{stall[5:2], stall[0], branch_target_i[1:0]};

    assign valid       = (count != '0);
    assign pop         = !stall[1] && valid;
    assign req_ack     = (state == REQ) && imem.inst_ack_i;
    assign push        = req_ack && !branch_flag_i;
    assign count_after = count + (PW+1)'(push) - (PW+1)'(pop);

    assign imem.inst_req_o  = (state == REQ) || (state == DRAIN);
    assign imem.inst_addr_o = (state == DRAIN) ? drain_addr : fetch_pc;

    assign if_pc       = valid ? pc_mem[rd_ptr]   : 32'h0;
    assign if_inst     = valid ? inst_mem[rd_ptr] : 32'h0;
    assign stallreq_if = rst_n && !valid;

    // Next fetch state: issue while space exists, drain an orphaned request on redirect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (branch_flag_i || (count < FULL))
                    state_next = REQ;
            end
            REQ: begin
                if (branch_flag_i)
                    state_next = imem.inst_ack_i ? IDLE : DRAIN;
                else if (imem.inst_ack_i)
                    state_next = (count_after < FULL) ? REQ : IDLE;
            end
            DRAIN: begin
                if (imem.inst_ack_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any outstanding request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Fetch address: redirect wins, otherwise advance by one word per accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_pc <= {RESET_PC[31:2], 2'b00};
        else if (branch_flag_i)
            fetch_pc <= {branch_target_i[31:2], 2'b00};
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

    // Remember the address of a request orphaned by a redirect so it stays stable while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drain_addr <= 32'h0;
        else if ((state == REQ) && branch_flag_i && !imem.inst_ack_i)
            drain_addr <= fetch_pc;
    end

    // FIFO pointers and occupancy, including the redirect flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_flag_i && (state != DRAIN)) begin
`ifdef IF_DELAY_SLOT_EN
            if (valid && !pop) begin
                wr_ptr <= rd_ptr + PW'(1);
                count  <= (PW+1)'(1);
            end else begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end
`else
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_after;
        end
    end

    // FIFO storage: capture the returned word together with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= imem.inst_rdata_i;
        end
    end

    // The issue rule must never let a push land in a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == FULL)));

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Testbench for if_fetch_buffer: random stall/redirect/memory-latency traffic
// checked against a program-order model of the instruction stream.
module tb_if_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    if_fetch_buffer_if imem_bus ();

    if_fetch_buffer #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem            (imem_bus),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq_if     (stallreq_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc;
    logic [31:0] ds_target;
    bit          ds_pending;
    int          consumed;
    int          empty_run;
    int          max_empty_run;

    int          lat_mode;
    int          mem_lat;
    int          mem_wcnt;
    bit          mem_pend;
    logic [31:0] mem_paddr;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC3A5_1E0F;
    endfunction

    function automatic int pickLat();
        return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        exp_pc     = 32'h0;
        ds_pending = 1'b0;
        ds_target  = 32'h0;
        empty_run  = 0;
        mem_pend   = 1'b0;
        mem_wcnt   = 0;
        mem_lat    = pickLat();
    endtask

    // One clock cycle: memory responder, input drive, and program-order check.
    task automatic applyStimulus(input logic [5:0] st, input logic br, input logic [31:0] tgt);
        bit valid;
        bit take;
        @(negedge clk);

        if (!imem_bus.inst_req_o) begin
            if (mem_pend)
                checkOutput("req_held", {31'b0, imem_bus.inst_req_o}, 32'd1);
            mem_pend              = 1'b0;
            mem_wcnt              = 0;
            imem_bus.inst_ack_i   = 1'b0;
            imem_bus.inst_rdata_i = $urandom;
        end else begin
            if (mem_pend)
                checkOutput("addr_stable", imem_bus.inst_addr_o, mem_paddr);
            checkOutput("addr_align", {30'b0, imem_bus.inst_addr_o[1:0]}, 32'd0);
            if (mem_wcnt >= mem_lat) begin
                imem_bus.inst_ack_i   = 1'b1;
                imem_bus.inst_rdata_i = memWord(imem_bus.inst_addr_o);
                mem_pend              = 1'b0;
                mem_wcnt              = 0;
                mem_lat               = pickLat();
            end else begin
                imem_bus.inst_ack_i   = 1'b0;
                imem_bus.inst_rdata_i = $urandom;
                mem_pend              = 1'b1;
                mem_paddr             = imem_bus.inst_addr_o;
                mem_wcnt++;
            end
        end

        stall           = st;
        branch_flag_i   = br;
        branch_target_i = tgt;

        valid = !stallreq_if;
        take  = valid && !st[1];
        if (valid) begin
            checkOutput("head_pc", if_pc, exp_pc);
            checkOutput("head_inst", if_inst, memWord(exp_pc));
            empty_run = 0;
        end else begin
            checkOutput("empty_pc", if_pc, 32'h0);
            checkOutput("empty_inst", if_inst, 32'h0);
            empty_run++;
            if (empty_run > max_empty_run)
                max_empty_run = empty_run;
        end

        if (take) begin
            consumed++;
            if (ds_pending) begin
                exp_pc     = ds_target;
                ds_pending = 1'b0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end

        if (br) begin
            empty_run = 0;
`ifdef IF_DELAY_SLOT_EN
            if (valid && !take) begin
                ds_pending = 1'b1;
                ds_target  = tgt;
            end else begin
                exp_pc     = tgt;
                ds_pending = 1'b0;
            end
`else
            exp_pc = tgt;
`endif
        end
    endtask

    task automatic randomSteps(input int n);
        logic [5:0]  st;
        logic        br;
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            st    = 6'($urandom);
            st[1] = ($urandom_range(0, 99) < 35);
            br    = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 9) == 0)
                tgt = 32'hFFFF_FFF8;
            else
                tgt = 32'($urandom_range(0, 1023)) << 2;
            applyStimulus(st, br, tgt);
        end
    endtask

    initial begin
        int  first_idx;
        bit  found;

        rst_n                 = 1'b0;
        stall                 = 6'b0;
        branch_flag_i         = 1'b0;
        branch_target_i       = 32'h0;
        imem_bus.inst_ack_i   = 1'b0;
        imem_bus.inst_rdata_i = 32'h0;
        consumed              = 0;
        max_empty_run         = 0;
        lat_mode              = 0;
        modelReset();

        repeat (3) @(negedge clk);
        checkOutput("rst_req", {31'b0, imem_bus.inst_req_o}, 32'd0);
        checkOutput("rst_pc", if_pc, 32'h0);
        checkOutput("rst_inst", if_inst, 32'h0);
        checkOutput("rst_stallreq", {31'b0, stallreq_if}, 32'd0);
        rst_n = 1'b1;

        // Zero-wait memory, no stall: first valid after two edges, then one per cycle.
        first_idx = -1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(6'b0, 1'b0, 32'h0);
            if ((first_idx < 0) && !stallreq_if)
                first_idx = i + 1;
        end
        checkOutput("first_valid_lat", first_idx, 32'd2);

        // Redirect near the top of the address space exercises 32-bit wrap.
        applyStimulus(6'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++)
            applyStimulus(6'b0, 1'b0, 32'h0);

        // Three-cycle memory, with a redirect to 0x100 while a request is pending.
        lat_mode = 3;
        for (int i = 0; i < 40; i++)
            applyStimulus(6'b0, (i == 13), 32'h100);

        // Hold the hand-over: buffer fills, requests stop, head stays put.
        lat_mode = 0;
        for (int i = 0; i < 10; i++)
            applyStimulus(6'b000010, 1'b0, 32'h0);
        checkOutput("full_req_low", {31'b0, imem_bus.inst_req_o}, 32'd0);
        checkOutput("full_not_starved", {31'b0, stallreq_if}, 32'd0);
        for (int i = 0; i < 10; i++)
            applyStimulus(6'b0, 1'b0, 32'h0);

        // Redirect while the hand-over is stalled.
        applyStimulus(6'b000010, 1'b1, 32'h40);
        for (int i = 0; i < 10; i++)
            applyStimulus(6'b0, 1'b0, 32'h0);

        lat_mode = -1;
        randomSteps(1500);

        // Reset in the middle of a handshake, with a late ack arriving during reset.
        lat_mode = 3;
        found    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(6'b0, 1'b0, 32'h0);
            found = mem_pend && imem_bus.inst_req_o;
        end
        checkOutput("reset_setup", {31'b0, found}, 32'd1);
        rst_n                 = 1'b0;
        imem_bus.inst_ack_i   = 1'b1;
        imem_bus.inst_rdata_i = 32'hDEAD_BEEF;
        #1;
        checkOutput("midrst_req", {31'b0, imem_bus.inst_req_o}, 32'd0);
        checkOutput("midrst_pc", if_pc, 32'h0);
        checkOutput("midrst_stallreq", {31'b0, stallreq_if}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("midrst_req_hold", {31'b0, imem_bus.inst_req_o}, 32'd0);
        imem_bus.inst_ack_i = 1'b0;
        @(negedge clk);
        lat_mode = -1;
        modelReset();
        rst_n = 1'b1;
        randomSteps(400);

        checkOutput("progress", {31'b0, (consumed > 400)}, 32'd1);
        checkOutput("max_starve", {31'b0, (max_empty_run <= 20)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
